// File: rtl/cpu_bus_responder.sv
// cpu_bus_responder
//
// Bus-side responder for the 6502 core's external address/data bus. It decodes
// every CPU access and serves the 2 KB work RAM, which is mirrored across
// $0000-RAM_TOP. It also runs the sprite (OAM) DMA engine, which is triggered
// by a CPU write to DMA_REG. While DMA owns the RAM, rdy is held low.
//
// Build option: define OAM_DMA_EN to implement the DMA engine. When it is not
// defined, DMA_REG writes are ignored, rdy is tied high and the OAM port is
// tied to zero.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     asynchronous, active-high reset
//   addr      CPU address bus
//   r_w_n     CPU read (1) / write (0)
//   d_in      write data from the CPU
//   d_out     registered read data toward the CPU (holds on open-bus cycles)
//   d_oe      responder drives the data bus this cycle
//   rdy       0 halts the CPU (DMA in progress)
//   oam_we    OAM write strobe, one cycle per byte
//   oam_addr  OAM byte index
//   oam_data  OAM write data

module cpu_bus_responder #(
    parameter int unsigned RAM_AW  = 11,
    parameter logic [15:0] RAM_TOP = 16'h1FFF,
    parameter logic [15:0] DMA_REG = 16'h4014
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        r_w_n,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    output logic        rdy,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data
);

    localparam int unsigned RamWords = 1 << RAM_AW;

    // Work RAM; contents are deliberately not reset.
    logic [7:0] mem [RamWords];

    logic ram_hit;
    logic cpu_rd;
    logic cpu_wr;

    assign ram_hit = (addr <= RAM_TOP);
    // CPU accesses only take effect while the CPU owns the bus.
    assign cpu_rd  = rdy && r_w_n && ram_hit;
    assign cpu_wr  = rdy && !r_w_n && ram_hit;

    always_ff @(posedge clk) begin
        if (cpu_wr) begin
            mem[addr[RAM_AW-1:0]] <= d_in;
        end
    end

    // d_out only updates on a read hit, so unmapped reads leave the last value
    // on the bus (open bus behaviour).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_out <= 8'h00;
            d_oe  <= 1'b0;
        end else begin
            d_oe <= cpu_rd;
            if (cpu_rd) begin
                d_out <= mem[addr[RAM_AW-1:0]];
            end
        end
    end

`ifdef OAM_DMA_EN

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StRead,
        StWrite
    } dma_state_e;

    dma_state_e  state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;      // byte index k, doubles as oam_addr
    logic [7:0]  byte_q, byte_d;    // byte fetched in READ(k), shown in WRITE(k)
    logic [15:0] dma_addr;

    assign dma_addr = {page_q, idx_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            page_q  <= 8'h00;
            idx_q   <= 8'h00;
            byte_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            page_q  <= page_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        page_d  = page_q;
        idx_d   = idx_q;
        byte_d  = byte_q;
        unique case (state_q)
            StIdle: begin
                if (!r_w_n && (addr == DMA_REG)) begin
                    page_d  = d_in;
                    state_d = StAlign;
                end
            end
            StAlign: begin
                state_d = StRead;
            end
            StRead: begin
                // Source pages beyond the RAM window read back as $FF.
                byte_d  = (dma_addr <= RAM_TOP) ? mem[dma_addr[RAM_AW-1:0]] : 8'hFF;
                state_d = StWrite;
            end
            StWrite: begin
                // 8-bit wrap returns the index to 0 after byte 255.
                idx_d   = idx_q + 8'd1;
                state_d = (idx_q == 8'hFF) ? StIdle : StRead;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rdy      = (state_q == StIdle);
    assign oam_we   = (state_q == StWrite);
    assign oam_addr = idx_q;
    assign oam_data = byte_q;

`else

    logic unused_dma_reg;
    assign unused_dma_reg = ^DMA_REG;

    assign rdy      = 1'b1;
    assign oam_we   = 1'b0;
    assign oam_addr = 8'h00;
    assign oam_data = 8'h00;

`endif

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Testbench for cpu_bus_responder. A transaction-level reference model keeps a
// byte array for RAM and represents a DMA as "started at edge E0 on page P".
// From these it derives rdy, the OAM strobe, the index and the data using the
// cycle offset since E0. Every cycle is compared against this model, and
// literal expectations pin the model itself.

module tb_cpu_bus_responder;

`ifdef OAM_DMA_EN
    localparam bit DmaEn = 1'b1;
`else
    localparam bit DmaEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic        r_w_n;
    logic [7:0]  d_in;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        rdy;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;

    cpu_bus_responder dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .r_w_n    (r_w_n),
        .d_in     (d_in),
        .d_out    (d_out),
        .d_oe     (d_oe),
        .rdy      (rdy),
        .oam_we   (oam_we),
        .oam_addr (oam_addr),
        .oam_data (oam_data)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stall_cnt = 0;
    int we_cnt = 0;
    logic [7:0] last_data = 8'h00;

    // Reference model state.
    logic [7:0] ram [0:2047];
    logic [7:0] m_dout;
    logic       m_doe;
    logic       m_active;
    int         m_n;        // edges since the trigger edge E0
    logic [7:0] m_page;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_n      = 0;
        m_dout   = 8'h00;
        m_doe    = 1'b0;
        m_page   = 8'h00;
    endtask

    // Applies the bus rules for one rising edge using the inputs held across it.
    task automatic model_edge();
        logic stalled;
        if (reset) begin
            model_reset();
            return;
        end
        stalled = m_active;
        if (m_active) begin
            m_n++;
            if (m_n == 513) m_active = 1'b0;
        end
        if (stalled) begin
            m_doe = 1'b0;
        end else if (addr <= 16'h1FFF) begin
            if (r_w_n) begin
                m_doe  = 1'b1;
                m_dout = ram[addr[10:0]];
            end else begin
                m_doe = 1'b0;
                ram[addr[10:0]] = d_in;
            end
        end else begin
            m_doe = 1'b0;
            if (!r_w_n && addr == 16'h4014 && DmaEn) begin
                m_active = 1'b1;
                m_n      = 0;
                m_page   = d_in;
            end
        end
    endtask

    task automatic compare();
        logic       we_exp;
        logic [7:0] idx_exp;
        logic [15:0] src;
        we_exp  = m_active && (m_n >= 2) && (m_n % 2 == 0);
        idx_exp = (m_active && m_n >= 1) ? 8'((m_n - 1) / 2) : 8'h00;
        chk("rdy", 32'(rdy), 32'(!m_active));
        chk("oam_we", 32'(oam_we), 32'(we_exp));
        chk("oam_addr", 32'(oam_addr), 32'(idx_exp));
        chk("d_oe", 32'(d_oe), 32'(m_doe));
        chk("d_out", 32'(d_out), 32'(m_dout));
        if (we_exp) begin
            src = {m_page, idx_exp};
            chk("oam_data", 32'(oam_data), (src <= 16'h1FFF) ? 32'(ram[src[10:0]]) : 32'hFF);
        end
        if (rdy === 1'b0) stall_cnt++;
        if (oam_we === 1'b1) begin
            we_cnt++;
            last_data = oam_data;
        end
    endtask

    // Compare before the edge, advance the model at the edge, return just after.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_bus(input logic [15:0] a, input logic rw, input logic [7:0] d);
        addr  = a;
        r_w_n = rw;
        d_in  = d;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        set_bus(a, 1'b0, d);
        tick();
    endtask

    task automatic rd(input logic [15:0] a);
        set_bus(a, 1'b1, 8'h00);
        tick();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            rd(16'h8000);
        end
    endtask

    task automatic rand_access();
        int unsigned r;
        logic [15:0] a;
        r = $urandom_range(0, 199);
        if (r == 0) a = 16'h4014;
        else if (r < 140) a = 16'($urandom_range(0, 16'h1FFF));
        else a = 16'($urandom_range(16'h2000, 16'hFFFF));
        set_bus(a, 1'($urandom_range(0, 1)), 8'($urandom));
        tick();
    endtask

    initial begin
        int s0;
        int w0;
        reset = 1'b1;
        set_bus(16'h0000, 1'b1, 8'h00);
        model_reset();
        for (int i = 0; i < 2048; i++) ram[i] = 8'h00;

        // Reset with random bus activity.
        for (int i = 0; i < 6; i++) rand_access();
        chk("reset_rdy", 32'(rdy), 32'h1);
        chk("reset_d_oe", 32'(d_oe), 32'h0);
        reset = 1'b0;

        // Give every RAM byte a known value.
        for (int i = 0; i < 2048; i++) wr(16'(i), 8'($urandom));
        wr(16'h0000, 8'h11);

        // Mirroring and open bus.
        wr(16'h0005, 8'hA5);
        rd(16'h1805);
        chk("lit_rd_1805", 32'(d_out), 32'hA5);
        chk("lit_oe_1805", 32'(d_oe), 32'h1);
        rd(16'h0805);
        chk("lit_rd_0805", 32'(d_out), 32'hA5);
        rd(16'h6000);
        chk("lit_open_oe", 32'(d_oe), 32'h0);
        chk("lit_open_dout", 32'(d_out), 32'hA5);
        wr(16'h6000, 8'h99);
        rd(16'h0000);
        chk("lit_unmapped_wr", 32'(d_out), 32'h11);

        // DMA from page $02 with value = index ^ $3C, plus CPU traffic during it.
        for (int i = 0; i < 256; i++) wr(16'h0200 + 16'(i), 8'(i) ^ 8'h3C);
        s0 = stall_cnt;
        w0 = we_cnt;
        wr(16'h4014, 8'h02);
        for (int i = 0; i < 520; i++) begin
            if (i == 10) wr(16'h0000, 8'h77);
            else if (i == 20) wr(16'h4014, 8'h05);
            else rd(16'h8000);
        end
        chk("lit_stall_cycles", 32'(stall_cnt - s0), DmaEn ? 32'd513 : 32'd0);
        chk("lit_we_pulses", 32'(we_cnt - w0), DmaEn ? 32'd256 : 32'd0);
        chk("lit_last_data", 32'(last_data), DmaEn ? 32'hC3 : 32'h00);
        rd(16'h0000);
        chk("lit_ram_during_dma", 32'(d_out), DmaEn ? 32'h11 : 32'h77);

        // Page above the RAM window supplies $FF.
        w0 = we_cnt;
        wr(16'h4014, 8'h21);
        idle_ticks(520);
        chk("lit_ff_pulses", 32'(we_cnt - w0), DmaEn ? 32'd256 : 32'd0);
        chk("lit_ff_data", 32'(last_data), DmaEn ? 32'hFF : 32'h00);

        // Reset in the middle of a DMA, at WRITE(100).
        wr(16'h4014, 8'h02);
        idle_ticks(202);
        chk("lit_byte100_we", 32'(oam_we), 32'(DmaEn));
        chk("lit_byte100_addr", 32'(oam_addr), DmaEn ? 32'd100 : 32'd0);
        reset = 1'b1;
        model_reset();
        #1;
        chk("lit_midreset_rdy", 32'(rdy), 32'h1);
        chk("lit_midreset_we", 32'(oam_we), 32'h0);
        chk("lit_midreset_addr", 32'(oam_addr), 32'h0);
        idle_ticks(2);
        reset = 1'b0;
        w0 = we_cnt;
        wr(16'h4014, 8'h02);
        idle_ticks(520);
        chk("lit_restart_pulses", 32'(we_cnt - w0), DmaEn ? 32'd256 : 32'd0);
        chk("lit_restart_last", 32'(last_data), DmaEn ? 32'hC3 : 32'h00);

        // Random traffic, including occasional DMA triggers.
        for (int i = 0; i < 3000; i++) rand_access();
        idle_ticks(520);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
